// File: rtl/pic_pkg.sv
// Shared types and constants for the PIC command sequencer.
package pic_pkg;

    typedef enum logic [2:0] {
        WAIT_ICW1,
        WAIT_ICW2,
        WAIT_ICW3,
        WAIT_ICW4,
        READY
    } state_t;

    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_ICW1,
        CMD_HI,
        CMD_OCW2,
        CMD_OCW3
    } cmd_t;

    localparam logic [2:0] ROT_AEOI_CLR = 3'b000;
    localparam logic [2:0] NS_EOI       = 3'b001;
    localparam logic [2:0] SP_EOI       = 3'b011;
    localparam logic [2:0] ROT_AEOI_SET = 3'b100;
    localparam logic [2:0] ROT_NS_EOI   = 3'b101;
    localparam logic [2:0] SET_PRI      = 3'b110;
    localparam logic [2:0] ROT_SP       = 3'b111;

    localparam int unsigned ICW1_IC4  = 0;
    localparam int unsigned ICW1_SNGL = 1;
    localparam int unsigned ICW1_LTIM = 3;
    localparam int unsigned ICW1_SEL  = 4;

    localparam int unsigned ICW4_UPM  = 0;
    localparam int unsigned ICW4_AEOI = 1;
    localparam int unsigned ICW4_MS   = 2;
    localparam int unsigned ICW4_BUF  = 3;
    localparam int unsigned ICW4_SFNM = 4;

    localparam int unsigned OCW3_RIS  = 0;
    localparam int unsigned OCW3_RR   = 1;
    localparam int unsigned OCW3_P    = 2;
    localparam int unsigned OCW3_SEL  = 3;
    localparam int unsigned OCW3_SMM  = 5;
    localparam int unsigned OCW3_ESMM = 6;

    // State that follows ICW2: ICW3 only for cascaded setups, then ICW4 if requested.
    function automatic state_t next_after_icw2(input logic cascaded, input logic ic4);
        if (cascaded)
            return WAIT_ICW3;
        else if (ic4)
            return WAIT_ICW4;
        else
            return READY;
    endfunction

endpackage

// File: rtl/pic_cmd_decode.sv
// Classifies a CPU write by {A0, D4, D3}; ICW1 wins over every other decode.
module pic_cmd_decode
    import pic_pkg::*;
(
    input  logic strobe,
    input  logic a0,
    input  logic d4,
    input  logic d3,
    output cmd_t cmd
);

    always_comb begin
        cmd = CMD_NONE;
        if (strobe) begin
            if (!a0 && d4)
                cmd = CMD_ICW1;
            else if (a0)
                cmd = CMD_HI;
            else if (d3)
                cmd = CMD_OCW3;
            else
                cmd = CMD_OCW2;
        end
    end

endmodule

// File: rtl/pic_command_sequencer.sv
// ICW sequencing, configuration/mask registers and OCW command pulses.
// Define CASCADE_EN to enable the ICW3 step, cascade_cfg and ms.
module pic_command_sequencer
    import pic_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       write_strobe,
    input  logic       A0,
    input  logic [7:0] internal_bus,
    output logic       init_done,
    output logic       ltim,
    output logic       sngl,
    output logic       ic4,
    output logic [4:0] vector_base,
    output logic [7:0] cascade_cfg,
    output logic       upm,
    output logic       aeoi,
    output logic       ms,
    output logic       buf_mode,
    output logic       sfnm,
    output logic [7:0] imr,
    output logic       special_mask,
    output logic       read_isr,
    output logic       rotate_aeoi,
    output logic       ocw2_valid,
    output logic [2:0] ocw2_cmd,
    output logic [2:0] ocw2_level,
    output logic       poll_req,
    output logic       icw1_clear
);

    state_t state;
    cmd_t   cmd;
    state_t icw2_next;
    state_t icw3_next;
    logic   cascaded;

    pic_cmd_decode u_decode (
        .strobe (write_strobe),
        .a0     (A0),
        .d4     (internal_bus[ICW1_SEL]),
        .d3     (internal_bus[OCW3_SEL]),
        .cmd    (cmd)
    );

`ifdef CASCADE_EN
    assign cascaded = ~sngl;
`else
    assign cascaded = 1'b0;
    assign cascade_cfg = 8'h00;
    assign ms = 1'b0;
`endif

    assign icw2_next = next_after_icw2(cascaded, ic4);
    assign icw3_next = ic4 ? WAIT_ICW4 : READY;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= WAIT_ICW1;
            init_done    <= 1'b0;
            ltim         <= 1'b0;
            sngl         <= 1'b0;
            ic4          <= 1'b0;
            vector_base  <= 5'h00;
            upm          <= 1'b0;
            aeoi         <= 1'b0;
            buf_mode     <= 1'b0;
            sfnm         <= 1'b0;
            imr          <= 8'h00;
            special_mask <= 1'b0;
            read_isr     <= 1'b0;
            rotate_aeoi  <= 1'b0;
            ocw2_valid   <= 1'b0;
            ocw2_cmd     <= 3'b000;
            ocw2_level   <= 3'b000;
            poll_req     <= 1'b0;
            icw1_clear   <= 1'b0;
`ifdef CASCADE_EN
            cascade_cfg  <= 8'h00;
            ms           <= 1'b0;
`endif
        end else begin
            ocw2_valid <= 1'b0;
            poll_req   <= 1'b0;
            icw1_clear <= 1'b0;
            case (cmd)
                CMD_ICW1: begin
                    ltim         <= internal_bus[ICW1_LTIM];
                    sngl         <= internal_bus[ICW1_SNGL];
                    ic4          <= internal_bus[ICW1_IC4];
                    imr          <= 8'h00;
                    special_mask <= 1'b0;
                    read_isr     <= 1'b0;
                    rotate_aeoi  <= 1'b0;
                    upm          <= 1'b0;
                    aeoi         <= 1'b0;
                    buf_mode     <= 1'b0;
                    sfnm         <= 1'b0;
`ifdef CASCADE_EN
                    ms           <= 1'b0;
`endif
                    init_done    <= 1'b0;
                    icw1_clear   <= 1'b1;
                    state        <= WAIT_ICW2;
                end
                CMD_HI: begin
                    case (state)
                        WAIT_ICW2: begin
                            vector_base <= internal_bus[7:3];
                            state       <= icw2_next;
                            init_done   <= (icw2_next == READY);
                        end
`ifdef CASCADE_EN
                        WAIT_ICW3: begin
                            cascade_cfg <= internal_bus;
                            state       <= icw3_next;
                            init_done   <= (icw3_next == READY);
                        end
`endif
                        WAIT_ICW4: begin
                            upm       <= internal_bus[ICW4_UPM];
                            aeoi      <= internal_bus[ICW4_AEOI];
                            buf_mode  <= internal_bus[ICW4_BUF];
                            sfnm      <= internal_bus[ICW4_SFNM];
`ifdef CASCADE_EN
                            ms        <= internal_bus[ICW4_MS];
`endif
                            state     <= READY;
                            init_done <= 1'b1;
                        end
                        READY:   imr <= internal_bus;
                        default: ;
                    endcase
                end
                CMD_OCW2: begin
                    if (state == READY) begin
                        ocw2_valid <= 1'b1;
                        ocw2_cmd   <= internal_bus[7:5];
                        ocw2_level <= internal_bus[2:0];
                        if (internal_bus[7:5] == ROT_AEOI_SET)
                            rotate_aeoi <= 1'b1;
                        else if (internal_bus[7:5] == ROT_AEOI_CLR)
                            rotate_aeoi <= 1'b0;
                    end
                end
                CMD_OCW3: begin
                    if (state == READY) begin
                        if (internal_bus[OCW3_ESMM])
                            special_mask <= internal_bus[OCW3_SMM];
                        if (internal_bus[OCW3_RR])
                            read_isr <= internal_bus[OCW3_RIS];
                        if (internal_bus[OCW3_P])
                            poll_req <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pic_command_sequencer.sv
// Self-checking bench for pic_command_sequencer: directed table, corner sequences, random writes.
module tb_pic_command_sequencer;

`ifdef CASCADE_EN
    localparam bit CAS = 1'b1;
`else
    localparam bit CAS = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       write_strobe;
    logic       A0;
    logic [7:0] internal_bus;
    logic       init_done, ltim, sngl, ic4;
    logic [4:0] vector_base;
    logic [7:0] cascade_cfg;
    logic       upm, aeoi, ms, buf_mode, sfnm;
    logic [7:0] imr;
    logic       special_mask, read_isr, rotate_aeoi;
    logic       ocw2_valid;
    logic [2:0] ocw2_cmd, ocw2_level;
    logic       poll_req, icw1_clear;

    pic_command_sequencer dut (
        .clk(clk), .reset(reset), .write_strobe(write_strobe), .A0(A0),
        .internal_bus(internal_bus), .init_done(init_done), .ltim(ltim),
        .sngl(sngl), .ic4(ic4), .vector_base(vector_base), .cascade_cfg(cascade_cfg),
        .upm(upm), .aeoi(aeoi), .ms(ms), .buf_mode(buf_mode), .sfnm(sfnm),
        .imr(imr), .special_mask(special_mask), .read_isr(read_isr),
        .rotate_aeoi(rotate_aeoi), .ocw2_valid(ocw2_valid), .ocw2_cmd(ocw2_cmd),
        .ocw2_level(ocw2_level), .poll_req(poll_req), .icw1_clear(icw1_clear)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int clr_seen = 0;

    // Reference model: remaining init words kept as a to-do list (2=ICW2, 3=ICW3, 4=ICW4).
    int         pend[$];
    bit         m_init, m_ltim, m_sngl, m_ic4;
    logic [4:0] m_vb;
    logic [7:0] m_cas, m_imr;
    bit         m_upm, m_aeoi, m_ms, m_buf, m_sfnm;
    bit         m_smm, m_ris, m_rot, m_ov, m_poll, m_clr;
    logic [2:0] m_cmd, m_lvl;

    task automatic model_reset();
        pend.delete();
        m_init = 0; m_ltim = 0; m_sngl = 0; m_ic4 = 0; m_vb = '0; m_cas = '0; m_imr = '0;
        m_upm = 0; m_aeoi = 0; m_ms = 0; m_buf = 0; m_sfnm = 0;
        m_smm = 0; m_ris = 0; m_rot = 0; m_ov = 0; m_poll = 0; m_clr = 0;
        m_cmd = '0; m_lvl = '0;
    endtask

    task automatic model_step(input bit s, input bit a0, input logic [7:0] d);
        int step;
        m_ov = 0; m_poll = 0; m_clr = 0;
        if (!s) return;
        if (!a0 && d[4]) begin
            m_ltim = d[3]; m_sngl = d[1]; m_ic4 = d[0];
            m_imr = '0; m_smm = 0; m_ris = 0; m_rot = 0;
            m_upm = 0; m_aeoi = 0; m_ms = 0; m_buf = 0; m_sfnm = 0;
            m_init = 0; m_clr = 1;
            pend.delete();
            pend.push_back(2);
            if (CAS && !d[1]) pend.push_back(3);
            if (d[0]) pend.push_back(4);
        end else if (pend.size() > 0) begin
            if (a0) begin
                step = pend.pop_front();
                if (step == 2) m_vb = d[7:3];
                else if (step == 3) m_cas = d;
                else begin
                    m_upm = d[0]; m_aeoi = d[1]; m_ms = CAS ? d[2] : 1'b0;
                    m_buf = d[3]; m_sfnm = d[4];
                end
                if (pend.size() == 0) m_init = 1;
            end
        end else if (m_init) begin
            if (a0) m_imr = d;
            else if (!d[3]) begin
                m_ov = 1; m_cmd = d[7:5]; m_lvl = d[2:0];
                if (d[7:5] == 3'b100) m_rot = 1;
                if (d[7:5] == 3'b000) m_rot = 0;
            end else begin
                if (d[6]) m_smm = d[5];
                if (d[1]) m_ris = d[0];
                if (d[2]) m_poll = 1;
            end
        end
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("init_done", 8'(init_done), 8'(m_init));
        chk("ltim", 8'(ltim), 8'(m_ltim));
        chk("sngl", 8'(sngl), 8'(m_sngl));
        chk("ic4", 8'(ic4), 8'(m_ic4));
        chk("vector_base", 8'(vector_base), 8'(m_vb));
        chk("cascade_cfg", cascade_cfg, m_cas);
        chk("upm", 8'(upm), 8'(m_upm));
        chk("aeoi", 8'(aeoi), 8'(m_aeoi));
        chk("ms", 8'(ms), 8'(m_ms));
        chk("buf_mode", 8'(buf_mode), 8'(m_buf));
        chk("sfnm", 8'(sfnm), 8'(m_sfnm));
        chk("imr", imr, m_imr);
        chk("special_mask", 8'(special_mask), 8'(m_smm));
        chk("read_isr", 8'(read_isr), 8'(m_ris));
        chk("rotate_aeoi", 8'(rotate_aeoi), 8'(m_rot));
        chk("ocw2_valid", 8'(ocw2_valid), 8'(m_ov));
        if (m_ov) begin
            chk("ocw2_cmd", 8'(ocw2_cmd), 8'(m_cmd));
            chk("ocw2_level", 8'(ocw2_level), 8'(m_lvl));
        end
        chk("poll_req", 8'(poll_req), 8'(m_poll));
        chk("icw1_clear", 8'(icw1_clear), 8'(m_clr));
    endtask

    // Drive one cycle from a negedge, sample at the next negedge.
    task automatic cyc(input bit s, input bit a0, input logic [7:0] d);
        write_strobe = s; A0 = a0; internal_bus = d;
        @(negedge clk);
        if (icw1_clear === 1'b1) clr_seen++;
        model_step(s, a0, d);
        check_all();
    endtask

    task automatic mid_cycle_reset();
        #2 reset = 1'b1;
        #1 model_reset();
        check_all();
        @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        bit         a0;
        logic [7:0] d;
        bit         init;
        logic [7:0] imr;
        logic [4:0] vb;
        logic [2:0] pulses;   // {icw1_clear, ocw2_valid, poll_req}
    } vec_t;

    vec_t tbl[7];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1'b0, 8'h13, 1'b0, 8'h00, 5'h00, 3'b100};
        tbl[1] = '{1'b1, 8'h20, 1'b0, 8'h00, 5'h04, 3'b000};
        tbl[2] = '{1'b1, 8'h01, 1'b1, 8'h00, 5'h04, 3'b000};
        tbl[3] = '{1'b1, 8'hA5, 1'b1, 8'hA5, 5'h04, 3'b000};
        tbl[4] = '{1'b0, 8'h63, 1'b1, 8'hA5, 5'h04, 3'b010};
        tbl[5] = '{1'b0, 8'h0C, 1'b1, 8'hA5, 5'h04, 3'b001};
        tbl[6] = '{1'b0, 8'h13, 1'b0, 8'h00, 5'h04, 3'b100};

        reset = 1'b1; write_strobe = 1'b0; A0 = 1'b0; internal_bus = 8'h00;
        model_reset();
        @(negedge clk);
        check_all();
        @(negedge clk);
        reset = 1'b0;
        cyc(0, 0, 8'h00);

        clr_seen = 0;
        for (int i = 0; i < 7; i++) begin
            cyc(1, tbl[i].a0, tbl[i].d);
            chk("tbl_init", 8'(init_done), 8'(tbl[i].init));
            chk("tbl_imr", imr, tbl[i].imr);
            chk("tbl_vb", 8'(vector_base), 8'(tbl[i].vb));
            chk("tbl_pulses", 8'({icw1_clear, ocw2_valid, poll_req}), 8'(tbl[i].pulses));
            if (i == 2) begin
                chk("single_upm", 8'(upm), 8'h01);
                chk("single_clr_count", 8'(clr_seen), 8'h01);
            end
            if (i == 4) begin
                chk("ocw2_cmd_63", 8'(ocw2_cmd), 8'h03);
                chk("ocw2_lvl_63", 8'(ocw2_level), 8'h03);
            end
        end
        cyc(0, 0, 8'h00);

        // Cascaded init (ICW3 only consumed when cascading is built in)
        cyc(1, 0, 8'h11);
        cyc(1, 1, 8'h08);
        if (CAS) cyc(1, 1, 8'h04);
        cyc(1, 1, 8'h1D);
        chk("cas_init", 8'(init_done), 8'h01);
        chk("cas_cfg", cascade_cfg, CAS ? 8'h04 : 8'h00);
        chk("cas_sfnm", 8'(sfnm), 8'h01);
        chk("cas_buf", 8'(buf_mode), 8'h01);
        chk("cas_ms", 8'(ms), CAS ? 8'h01 : 8'h00);
        chk("cas_aeoi", 8'(aeoi), 8'h00);
        chk("cas_upm", 8'(upm), 8'h01);
        cyc(0, 0, 8'h00);

        cyc(1, 0, 8'h80);
        chk("rot_set", 8'(rotate_aeoi), 8'h01);
        cyc(1, 0, 8'h00);
        chk("rot_clr", 8'(rotate_aeoi), 8'h00);
        chk("rot_clr_pulse", 8'(ocw2_valid), 8'h01);
        cyc(0, 0, 8'h00);
        cyc(1, 0, 8'h0B);
        chk("ocw3_ris", 8'(read_isr), 8'h01);
        cyc(1, 0, 8'h68);
        chk("ocw3_smm", 8'(special_mask), 8'h01);
        cyc(1, 0, 8'h0C);
        chk("ocw3_poll", 8'(poll_req), 8'h01);
        chk("poll_keep_ris", 8'(read_isr), 8'h01);
        chk("poll_keep_smm", 8'(special_mask), 8'h01);
        cyc(0, 0, 8'h00);
        chk("poll_drop", 8'(poll_req), 8'h00);

        // Reset while waiting for ICW4, then a stray A0=1 write must be ignored
        cyc(1, 0, 8'h13);
        cyc(1, 1, 8'h20);
        cyc(0, 0, 8'h00);
        mid_cycle_reset();
        chk("rst_vb", 8'(vector_base), 8'h00);
        cyc(1, 1, 8'hFF);
        chk("ignored_imr", imr, 8'h00);
        chk("ignored_vb", 8'(vector_base), 8'h00);
        chk("ignored_init", 8'(init_done), 8'h00);
        cyc(1, 0, 8'h13);
        mid_cycle_reset();
        chk("rst_mid_pulse", 8'(icw1_clear), 8'h00);

        // Random writes against the model
        for (int n = 0; n < 600; n++) begin
            bit         s, a0;
            logic [7:0] d;
            s  = ($urandom_range(0, 3) != 0);
            a0 = 1'($urandom_range(0, 1));
            d  = 8'($urandom);
            if (!a0 && d[4] && ($urandom_range(0, 5) != 0)) d[4] = 1'b0;
            cyc(s, a0, d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pic_command_sequencer.md
# pic_command_sequencer

Clocked command-decode and register stage directly downstream of the read/write logic. It consumes each CPU write (A0 plus the 8-bit internal bus) and tracks the ICW1→ICW2→[ICW3]→[ICW4] initialization sequence. It holds the resulting configuration and the interrupt mask, and emits one-cycle command pulses for OCW2 (EOI/rotate) and OCW3 (poll) to the priority resolver and in-service logic.

## Interface
- Reset is asynchronous and active-high (`reset`); one clock (`clk`).
- No parameters.
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- write_strobe  in  1  one-cycle pulse per completed CPU write, already synchronized to clk
- A0  in  1  address bit qualifying the write
- internal_bus  in  8  write data, valid while write_strobe=1
- init_done  out  1  sequence complete, OCWs accepted
- ltim, sngl, ic4  out  1 each  ICW1 D3, D1, D0
- vector_base  out  5  ICW2 D7..D3
- cascade_cfg  out  8  ICW3 byte
- upm, aeoi, ms, buf_mode, sfnm  out  1 each  ICW4 D0, D1, D2, D3, D4
- imr  out  8  interrupt mask (OCW1)
- special_mask  out  1  special mask mode
- read_isr  out  1  0=IRR, 1=ISR selected for status read
- rotate_aeoi  out  1  rotate-on-AEOI mode
- ocw2_valid  out  1  one-cycle pulse for an OCW2 command
- ocw2_cmd  out  3  {R,SL,EOI}, valid with ocw2_valid
- ocw2_level  out  3  L2..L0, valid with ocw2_valid
- poll_req  out  1  one-cycle pulse, OCW3 P=1
- icw1_clear  out  1  one-cycle pulse on every accepted ICW1

## Operation
- States: WAIT_ICW1, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY. Reset state is WAIT_ICW1.
- Writes are acted on only when write_strobe=1. All other cycles hold state.
- ICW1 (A0=0, D4=1) is accepted from any state and has priority over every other decode. On ICW1:
  - Latch ltim, sngl, ic4.
  - Clear imr, special_mask, read_isr, rotate_aeoi.
  - Clear ICW4 fields.
  - Drop init_done to 0 and pulse icw1_clear.
  - Go to WAIT_ICW2.
- WAIT_ICW2, A0=1: latch vector_base = D7..D3. Next state:
  - WAIT_ICW3 if sngl=0.
  - Otherwise WAIT_ICW4 if ic4=1.
  - Otherwise READY.
- WAIT_ICW3, A0=1: latch cascade_cfg. Next state is WAIT_ICW4 if ic4=1, else READY.
- WAIT_ICW4, A0=1: latch D4..D0 into the ICW4 fields, then go to READY.
- Writes with A0=0 and D4=0 during WAIT_ICW2/3/4 are ignored; state is unchanged.
- Writes during WAIT_ICW1 other than ICW1 are ignored.
- READY decode:
  - A0=1: OCW1, imr=D.
  - A0=0, D4=0, D3=0: OCW2. Pulse ocw2_valid with ocw2_cmd=D7..D5 and ocw2_level=D2..D0.
    - cmd 100 also sets rotate_aeoi; cmd 000 clears it.
    - Both of these still pulse ocw2_valid.
  - A0=0, D4=0, D3=1: OCW3.
    - If D6=1, special_mask=D5.
    - If D1=1, read_isr=D0.
    - If D2=1, pulse poll_req.
- init_done=1 exactly while in READY.

## Timing
- All outputs are registered.
- Latched fields and state update on the first clk edge where write_strobe=1. Outputs are visible the same cycle after that edge (latency 1).
- ocw2_valid, poll_req and icw1_clear are high for exactly one cycle per accepted write. Back-to-back strobes on consecutive cycles each produce their own pulse.
- Reset values: all outputs 0 (including imr=8'h00), state WAIT_ICW1.
- Reset asserted mid-sequence or mid-pulse forces reset values immediately, asynchronously.
- ICW1 arriving mid-sequence restarts cleanly. Partially written ICW2/ICW3 values keep their old contents until overwritten.

## Configuration
- CASCADE_EN defined: WAIT_ICW3 is used as described; cascade_cfg and ms are live.
- CASCADE_EN undefined:
  - The sngl bit is still latched, but the sequencer behaves as if sngl=1 and never enters WAIT_ICW3.
  - cascade_cfg is tied to 8'h00 and ms is tied to 0.

## Structure
- Shared package `pic_pkg`:
  - State encoding enum (5 states).
  - OCW2 command constants (NS_EOI=001, SP_EOI=011, ROT_NS_EOI=101, ROT_AEOI_SET=100, ROT_AEOI_CLR=000, ROT_SP=111, SET_PRI=110).
  - Bit-position constants for ICW1/ICW4/OCW3 fields.
- Sub-module `pic_cmd_decode`: combinational classification of {A0, D4, D3} into ICW1/HI/OCW2/OCW3/NONE. The FSM and registers live in the top module.

## Test plan
- Reset, then ICW1=8'h13 (single, IC4), ICW2=8'h20, ICW4=8'h01.
  - Required: vector_base=5'h04, upm=1, init_done=1.
  - WAIT_ICW3 is skipped.
  - icw1_clear pulses exactly once.
- With CASCADE_EN: ICW1=8'h11, ICW2=8'h08, ICW3=8'h04, ICW4=8'h1D.
  - Required: cascade_cfg=8'h04, sfnm=1, buf_mode=1, ms=1, aeoi=0, upm=1.
- After init: OCW1=8'hA5 gives imr=8'hA5. A subsequent ICW1 gives imr=8'h00, init_done=0.
- OCW2=8'h63 gives a single-cycle ocw2_valid with cmd=3'b011, level=3'd3.
  - OCW2=8'h80 sets rotate_aeoi=1.
  - OCW2=8'h00 clears it.
- OCW3=8'h0B gives read_isr=1.
  - OCW3=8'h68 gives special_mask=1.
  - OCW3=8'h0C pulses poll_req, with read_isr and special_mask unchanged.
- Assert reset while in WAIT_ICW4.
  - Required: all outputs 0 asynchronously.
  - The next A0=1 write is ignored until an ICW1 arrives.
